// File: rtl/com_loader.sv
// com_loader: host-side loader/unloader in front of the core's com_* DRAM port.
// It assembles host bytes into 16-bit words and writes them to DRAM, releases
// the core, waits for end_process, then streams a fixed result window back to
// the host. It is the only driver of status.
module com_loader #(
  parameter logic [15:0] RESULT_BASE = 16'h0000,
  parameter logic [15:0] RESULT_LEN  = 16'd16,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  status,
  output logic [15:0] com_addr,
  output logic [15:0] com_data_in,
  output logic        com_wr_en,
  input  logic [15:0] com_data_out,
  input  logic        end_process,
  output logic        busy,
  output logic        done
);

  // IDLE accepts the low count byte itself, so status reaches 01 in the cycle
  // right after that byte; the next state to consume a byte is CNT_HI.
  typedef enum logic [3:0] {
    IDLE, CNT_HI, DAT_LO, DAT_HI, WRITE, RUN, RD_ADDR, RD_WAIT, TX_LO, TX_HI
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

  state_t      state, state_nxt;
  logic [7:0]  lo_byte;     // low byte of the count or of the current word
  logic [15:0] word_total;  // N from the host header
  logic [15:0] word_cnt;    // k: next load address
  logic [15:0] rd_idx;      // i: readback word index
  logic [2:0]  wait_cnt;
  logic [7:0]  hi_hold;     // high byte of the word being returned

  logic rx_fire;
  logic word_last;
  logic rd_last;
  logic wait_last;

  assign rx_fire   = rx_valid && rx_ready;
  assign word_last = (word_cnt + 16'd1) == word_total;
  assign rd_last   = (rd_idx + 16'd1) == RESULT_LEN;
  assign wait_last = wait_cnt == WAIT_LAST;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (rx_fire) state_nxt = CNT_HI;
      CNT_HI:  if (rx_fire) state_nxt = ({rx_data, lo_byte} == 16'd0) ? RUN : DAT_LO;
      DAT_LO:  if (rx_fire) state_nxt = DAT_HI;
      DAT_HI:  if (rx_fire) state_nxt = WRITE;
      WRITE:   state_nxt = word_last ? RUN : DAT_LO;
      RUN:     if (end_process) state_nxt = RD_ADDR;
      RD_ADDR: state_nxt = RD_WAIT;
      RD_WAIT: if (wait_last) state_nxt = TX_LO;
      TX_LO:   if (tx_ready) state_nxt = TX_HI;
      TX_HI:   if (tx_ready) state_nxt = rd_last ? IDLE : RD_ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    status    = 2'b00;
    rx_ready  = 1'b0;
    com_wr_en = 1'b0;
    busy      = state != IDLE;
    unique case (state)
      IDLE:                   rx_ready = 1'b1;
      CNT_HI, DAT_LO, DAT_HI: begin status = 2'b01; rx_ready = 1'b1; end
      WRITE:                  begin status = 2'b01; com_wr_en = 1'b1; end
      RUN:                    status = 2'b10;
      RD_ADDR, RD_WAIT,
      TX_LO, TX_HI:           status = 2'b11;
      default:                status = 2'b00;
    endcase
  end

  // Datapath: byte latch, counters, DRAM address/data and the tx byte register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_byte     <= '0;
      word_total  <= '0;
      word_cnt    <= '0;
      rd_idx      <= '0;
      wait_cnt    <= '0;
      hi_hold     <= '0;
      com_addr    <= '0;
      com_data_in <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE:   if (rx_fire) lo_byte <= rx_data;
        CNT_HI: if (rx_fire) begin
          word_total <= {rx_data, lo_byte};
          word_cnt   <= '0;
        end
        DAT_LO: if (rx_fire) lo_byte <= rx_data;
        DAT_HI: if (rx_fire) begin
          com_addr    <= word_cnt;
          com_data_in <= {rx_data, lo_byte};
        end
        WRITE:  word_cnt <= word_cnt + 16'd1;
        RUN:    if (end_process) begin
          rd_idx   <= '0;
          com_addr <= RESULT_BASE;
        end
        RD_ADDR: wait_cnt <= '0;
        RD_WAIT: begin
          if (wait_last) begin
            tx_data  <= com_data_out[7:0];
            hi_hold  <= com_data_out[15:8];
            tx_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        TX_LO:  if (tx_ready) tx_data <= hi_hold;
        TX_HI:  if (tx_ready) begin
          tx_valid <= 1'b0;
          rd_idx   <= rd_idx + 16'd1;
          if (rd_last) done <= 1'b1;
          else         com_addr <= RESULT_BASE + rd_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_com_loader.sv
// Directed testbench for com_loader with a behavioural one-cycle-latency DRAM.
module tb_com_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [1:0]  status;
  logic [15:0] com_addr;
  logic [15:0] com_data_in;
  logic        com_wr_en;
  logic [15:0] com_data_out;
  logic        end_process = 1'b0;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  // DRAM model with backdoor preload port
  logic [15:0] mem [0:255];
  logic [15:0] mem_q = '0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  logic [15:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  com_loader #(
    .RESULT_BASE(16'h0010),
    .RESULT_LEN (16'd2),
    .READ_LAT   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .status      (status),
    .com_addr    (com_addr),
    .com_data_in (com_data_in),
    .com_wr_en   (com_wr_en),
    .com_data_out(com_data_out),
    .end_process (end_process),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign com_data_out = mem_q;

  always @(posedge clk) begin
    if (com_wr_en) mem[com_addr[7:0]] <= com_data_in;
    else if (pre_we) mem[pre_addr] <= pre_data;
    mem_q <= mem[com_addr[7:0]];
  end

  // Log every write strobe seen mid-cycle
  always @(negedge clk) begin
    if (com_wr_en === 1'b1) begin
      wr_addr_q.push_back(com_addr);
      wr_data_q.push_back(com_data_in);
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pre_we = 1'b1;
    pre_addr = 8'h10; pre_data = 16'hBEEF;
    @(negedge clk);
    pre_addr = 8'h11; pre_data = 16'h0042;
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({status, rx_ready, tx_valid, com_wr_en, busy, done} !== 7'b00_1_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_ctrl: status=%b rx_ready=%b tx_valid=%b wr_en=%b busy=%b done=%b required 00 1 0 0 0 0",
               status, rx_ready, tx_valid, com_wr_en, busy, done);
    end
    vectors++;
    if (tx_data !== 8'h00 || com_addr !== 16'h0000 || com_data_in !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: tx_data=%h com_addr=%h com_data_in=%h required 00 0000 0000",
               tx_data, com_addr, com_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Load 1234/ABCD while end_process is (wrongly) held high
  task automatic test_load();
    end_process = 1'b1;
    send_byte(8'h02);
    vectors++;
    if (status !== 2'b01) begin
      miscompares++;
      $display("FAIL load_status_after_first_byte: got %b required 01", status);
    end
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    vectors++;
    if (com_wr_en !== 1'b1 || com_addr !== 16'h0000 || com_data_in !== 16'h1234) begin
      miscompares++;
      $display("FAIL load_write0: wr_en=%b addr=%h data=%h required 1 0000 1234",
               com_wr_en, com_addr, com_data_in);
    end
    send_byte(8'hCD);
    send_byte(8'hAB);
    end_process = 1'b0;
    vectors++;
    if (status !== 2'b01 || com_wr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL load_write1_cycle: status=%b wr_en=%b required 01 1", status, com_wr_en);
    end
    @(negedge clk);
    vectors++;
    if (status !== 2'b10 || com_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL load_run_entry: status=%b wr_en=%b required 10 0", status, com_wr_en);
    end
    vectors++;
    if (wr_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL load_write_count: got %0d required 2", wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[1] !== 16'h0001 || wr_data_q[1] !== 16'hABCD) begin
        miscompares++;
        $display("FAIL load_write1: addr=%h data=%h required 0001 ABCD", wr_addr_q[1], wr_data_q[1]);
      end
    end
    // early end_process must not have started a readback
    repeat (4) @(negedge clk);
    vectors++;
    if (status !== 2'b10 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL end_ignored_in_load: status=%b tx_valid=%b required 10 0", status, tx_valid);
    end
  endtask

  // Pulse end_process in RUN and collect the 4 returned bytes
  task automatic run_readback(input bit stall);
    logic [7:0] exp_b [0:3];
    logic [7:0] got [0:3];
    int nb = 0;
    int ndone = 0;
    bit stalled = 1'b0;
    exp_b = '{8'hEF, 8'hBE, 8'h42, 8'h00};
    got   = '{8'h00, 8'h00, 8'h00, 8'h00};
    tx_ready = 1'b1;
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
    vectors++;
    if (status !== 2'b11 || com_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL rb_rd_addr: status=%b addr=%h required 11 0010", status, com_addr);
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rb_early_valid: tx_valid=%b required 0", tx_valid);
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
      miscompares++;
      $display("FAIL rb_first_byte: tx_valid=%b tx_data=%h required 1 EF", tx_valid, tx_data);
    end
    for (int c = 0; c < 40 && ndone == 0; c++) begin
      if (stall && nb == 1 && !stalled) begin
        stalled = 1'b1;
        tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          vectors++;
          if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
            miscompares++;
            $display("FAIL stall_hold: tx_valid=%b tx_data=%h required 1 BE", tx_valid, tx_data);
          end
        end
        tx_ready = 1'b1;
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (nb < 4) got[nb] = tx_data;
        nb++;
      end
      if (done === 1'b1) begin
        ndone++;
        vectors++;
        if (status !== 2'b00 || busy !== 1'b0 || (!stall && c != 6)) begin
          miscompares++;
          $display("FAIL rb_done_cycle: status=%b busy=%b cycle=%0d required 00 0 6", status, busy, c);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (nb != 4 || ndone != 1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rb_counts: bytes=%0d done_pulses=%0d done_now=%b required 4 1 0", nb, ndone, done);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k] !== exp_b[k]) begin
        miscompares++;
        $display("FAIL rb_byte%0d: got %h required %h", k, got[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_readback();
    run_readback(1'b0);
  endtask

  task automatic test_zero_count();
    int n_before = wr_addr_q.size();
    send_byte(8'h00);
    send_byte(8'h00);
    vectors++;
    if (status !== 2'b10 || com_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_run_entry: status=%b wr_en=%b required 10 0", status, com_wr_en);
    end
    vectors++;
    if (wr_addr_q.size() != n_before) begin
      miscompares++;
      $display("FAIL zero_no_write: writes=%0d required %0d", wr_addr_q.size(), n_before);
    end
  endtask

  task automatic test_tx_stall();
    run_readback(1'b1);
  endtask

  task automatic test_reset_mid_load();
    int n_before;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge clk);                  // WRITE of word 0 done, now DAT_LO
    send_byte(8'h77);                // now in DAT_HI of word 1
    n_before = wr_addr_q.size();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (status !== 2'b00 || com_wr_en !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: status=%b wr_en=%b busy=%b rx_ready=%b required 00 0 0 1",
               status, com_wr_en, busy, rx_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    vectors++;
    if (wr_addr_q.size() != n_before + 1) begin
      miscompares++;
      $display("FAIL mid_reset_write_count: got %0d required %0d", wr_addr_q.size(), n_before + 1);
    end else begin
      vectors++;
      if (wr_addr_q[n_before] !== 16'h0000 || wr_data_q[n_before] !== 16'h2211) begin
        miscompares++;
        $display("FAIL mid_reset_fresh_write: addr=%h data=%h required 0000 2211",
                 wr_addr_q[n_before], wr_data_q[n_before]);
      end
    end
    vectors++;
    if (status !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_reset_run: status=%b required 10", status);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_readback();
    test_zero_count();
    test_tx_stall();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/com_loader.md
# com_loader

Host-side loader/unloader that sits directly upstream of the processor top's `com_*` memory port and `status` input. It receives a byte stream from the host link, assembles 16-bit words and writes them into data memory through the selector. It then releases the core to run, waits for `end_process`, reads a fixed result window back out of memory and returns it to the host as bytes. It is the sole driver of `status`.

## Interface
Parameters:
- `RESULT_BASE`, 16'h0000: first DRAM address of the readback window.
- `RESULT_LEN`, 16'd16: number of words read back; must be ≥ 1.
- `READ_LAT`, 1: cycles from `com_addr` presented to `com_data_out` valid; legal range 1–4.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_data` in 8: host byte in.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `tx_data` out 8: byte to host.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: byte taken when `tx_valid && tx_ready`.
- `status` out 2: to top; 00 hold, 01 load (com owns DRAM), 10 run (core owns DRAM), 11 readback.
- `com_addr` out 16: DRAM address via selector.
- `com_data_in` out 16: write data.
- `com_wr_en` out 1: write strobe.
- `com_data_out` in 16: DRAM read data via selector.
- `end_process` in 1: core finished.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last readback byte is taken.

## Operation
- Reset values (all registered): state IDLE, `status`=00, `rx_ready`=1, `tx_valid`=0, `tx_data`=0, `com_addr`=0, `com_data_in`=0, `com_wr_en`=0, `busy`=0, `done`=0, word counter and byte latch 0.
- Host protocol: 16-bit word count N, low byte first; then N data words, each low byte then high byte. Word k is written to address k.
- States and transitions:
  - IDLE: waits for a byte.
  - CNT_LO: latches the low count byte.
  - CNT_HI: latches the high count byte. If N=0, go to RUN; otherwise go to DAT_LO.
  - DAT_LO: latches the data low byte.
  - DAT_HI: latches the data high byte, then goes to WRITE.
  - WRITE: one cycle, `com_wr_en`=1, `com_addr`=k, `com_data_in`={hi,lo}. Then k++; if k==N go to RUN, else go to DAT_LO.
  - RUN: holds until `end_process`=1, then goes to RD_ADDR.
  - RD_ADDR: presents `com_addr`=RESULT_BASE+i (mod 2^16) for one cycle.
  - RD_WAIT: waits READ_LAT cycles, then captures `com_data_out`.
  - TX_LO, TX_HI: send the captured word, low byte then high byte.
  - After TX_HI is taken: i++. If i==RESULT_LEN, pulse `done` and go to IDLE; otherwise go to RD_ADDR.
- `status` by state:
  - 00 in IDLE.
  - 01 in CNT_LO through WRITE. `status` changes to 01 in the cycle after the first count byte is accepted.
  - 10 in RUN.
  - 11 in RD_ADDR through TX_HI.
- `rx_ready`=1 only in IDLE, CNT_LO, CNT_HI, DAT_LO and DAT_HI; 0 elsewhere. `rx_valid` in other states is ignored and left pending.
- `com_wr_en` is 0 outside WRITE. `com_addr` holds its last value outside WRITE and RD_ADDR/RD_WAIT.
- `end_process` is ignored outside RUN.
- `tx_valid` rises on entry to TX_LO and stays high with `tx_data` stable until `tx_ready`. It stays high across the TX_LO→TX_HI step if the next byte is ready.

## Timing
- Load throughput: at most one word per 3 cycles (two byte handshakes plus WRITE).
- Write timing: the WRITE cycle immediately follows the cycle in which the high byte is accepted.
- RUN entry: `status`=10 the cycle after the last WRITE (or after the high count byte when N=0).
- RUN exit: `end_process` sampled high at edge t gives `status`=11 and RD_ADDR at t+1.
- Read latency: data captured READ_LAT cycles after RD_ADDR.
  - With READ_LAT=1 and `tx_ready` tied high, the first `tx_valid` appears 3 cycles after `end_process` is sampled.
  - Each word then takes 4 cycles.
- Readback address: RESULT_BASE+RESULT_LEN wraps past 16'hFFFF to 0.
- Reset mid-operation (any state, including mid-WRITE or mid-TX): all outputs take their reset values at that edge. The DRAM is not modified further, a partial byte latch is discarded, and `status` returns to 00.
- `done` and `busy`: `done` is high for exactly one cycle, coincident with IDLE entry; `busy` falls in the same cycle.

## Test plan
- Load N=2, words 16'h1234 and 16'hABCD (bytes 02 00 34 12 CD AB):
  - Expect two WRITE pulses: addr 0 data 1234, then addr 1 data ABCD.
  - `status` goes 01, then 10 on the cycle after the second write.
- N=0 (bytes 00 00):
  - No `com_wr_en` pulse.
  - `status`=10 the cycle after the second byte.
- With RESULT_BASE=16'h0010, RESULT_LEN=2, DRAM[10]=16'hBEEF, DRAM[11]=16'h0042, pulse `end_process`:
  - tx bytes EF BE 42 00.
  - `done` pulses once; `status` returns to 00.
- `tx_ready` held low 5 cycles mid-readback: `tx_valid` and `tx_data` stay constant, and no byte is dropped or repeated.
- `end_process` asserted during load: ignored; readback starts only after a second `end_process` in RUN.
- `rst_n` low during DAT_HI: next cycle `status`=00, `com_wr_en`=0, `busy`=0; a fresh load then writes from address 0.
